uart_tx_stream: RTL and testbench
=================================

// Module: uart_tx_stream
// PURPOSE
//   UART transmitter fed by an AXI Stream sink. Serialises 8-bit bytes onto txd as 8-N/E/O-1/2 frames.
//   Sits beside the UART receiver: its sink takes bytes from any AXIS producer (FIFO, CPU bridge, loopback).
//   Owns its handshake: a byte leaves the stream only on tvalid && tready.
// PARAMETERS
//   CLK_FREQ_HZ  100_000_000  frequency of clk, Hz
//   BAUD_RATE    115200       line rate, bits/s
//   PARITY_MODE  0            0 = none, 1 = even, 2 = odd
//   STOP_BITS    1            1 or 2; other values are an elaboration error
// PORTS
//   clk        input   1   single clock for all logic; tx_stream.clk is tied to clk
//   reset      input   1   synchronous, active-high
//   tx_stream  axis_interface.Sink  8   tdata byte, tvalid in, tready out
//   txd        output  1   serial line, registered, idle high
//   busy       output  1   high while a frame is in flight or the holding register is full
// BEHAVIOUR
//   Interface rule: one clock (clk); reset is synchronous and active-high.
//   Bit timing
//     CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE, rounded to nearest. Default is 868.
//     Elaboration error if CLKS_PER_BIT < 4.
//     Baud counter is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1.
//     Every serial bit is held for exactly CLKS_PER_BIT cycles.
//   Reset values
//     txd = 1, busy = 0, tready = 0 while reset is high; holding register empty; FSM in IDLE.
//     Reset mid-frame aborts the frame: txd = 1 on the next edge and the held byte is discarded.
//   Holding register (1 deep, decouples AXIS from the shifter)
//     tready = !reset && !hold_full; it is registered-state derived, with no combinational path from tvalid.
//     On handshake at edge E, tdata is captured and hold_full is set.
//     tdata/tvalid are ignored while tready = 0.
//     The shifter takes the held byte at frame start, which clears hold_full. tready rises one cycle later.
//     Load and unload never collide, because load requires hold_full = 0.
//   FSM states: IDLE, START, DATA, PARITY, STOP
//     IDLE: txd = 1. If hold_full, load the shifter, clear hold_full, go to START.
//     START: txd = 0 for one bit time, then DATA.
//     DATA: drive bits LSB first, bit_idx 0..7 (3 bits), one bit time each.
//       After bit 7: go to PARITY if PARITY_MODE != 0, else STOP.
//     PARITY: txd = ^byte for even, ~^byte for odd; one bit time, then STOP.
//     STOP: txd = 1 for STOP_BITS bit times.
//       At the end, if hold_full, load and go straight to START (no idle cycle), else go to IDLE.
//   Latency and throughput
//     Handshake at edge E: txd = 0 is visible after edge E+2 when the FSM is idle.
//     Back-to-back frame period is exactly CLKS_PER_BIT*(10 + (PARITY_MODE!=0) + (STOP_BITS-1)) cycles.
//   busy = (state != IDLE) || hold_full. It is 0 only when the line is idle and nothing is pending.
//   txd is driven only from a flop; no glitches.
// STRUCTURE
//   Package uart_pkg holds:
//     - uart_tx_state_t enum
//     - uart_parity_t enum (NONE/EVEN/ODD)
//     - function clks_per_bit(clk_hz, baud) with the rounding rule above
//   The package is shared with the UART receiver.
//   Sub-module uart_baud_gen(clk, reset, restart, tick) is the bit-time counter, reusable by the receiver.
//     It asserts tick on the last cycle of each bit time.
//     restart zeroes the count at frame start.
// TESTING
//   Sim config for all cases: CLK_FREQ_HZ=1_600_000, BAUD_RATE=100_000, so CLKS_PER_BIT=16.
//   1. Send 0x55 with PARITY_MODE=0, STOP_BITS=1
//      -> txd shows 0,1,0,1,0,1,0,1,0,1, each level 16 cycles; falling edge at E+2; busy drops 160 cycles after the frame starts.
//   2. Stream 0xA5, 0x3C, 0xFF with tvalid held high
//      -> three frames with no idle gap, frame period 160 cycles; tready pulses once per frame; bytes decoded in order.
//   3. PARITY_MODE=1 sending 0x07, then PARITY_MODE=2 sending 0x07
//      -> parity bit 1 for even, 0 for odd; frame length 176 cycles.
//   4. STOP_BITS=2 sending 0x00
//      -> data bits low, then txd high for 32 cycles before the next start bit; frame length 176 cycles.
//   5. Assert reset for 1 cycle in the middle of bit 3 of 0x81 while a second byte is held
//      -> txd=1 on the next edge, busy=0, tready=1 after reset releases, no further frame.
//   6. Change tdata every cycle while tvalid=1 and tready=0
//      -> the transmitted byte equals tdata at the handshake edge only; a scoreboard receiver matches every accepted byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity encodings and the
// clocks-per-bit rounding rule used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } uart_parity_t;

  // Nearest whole number of clk cycles per serial bit.
  function automatic int clks_per_bit(input longint clk_hz, input longint baud);
    return int'((clk_hz + baud / 2) / baud);
  endfunction

endpackage

// File: rtl/axis_interface.sv
// Minimal AXI Stream link (tdata/tvalid/tready) with producer and consumer views.
interface axis_interface #(
  parameter int DATA_W = 8
) (
  input logic clk
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport Source (output tdata, output tvalid, input tready);
  modport Sink   (input tdata, input tvalid, output tready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit time; restart realigns the count to the start of a new frame.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first (no latches); clocked blocks use only non-blocking '<='.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter with an AXI Stream sink: a one-byte holding register feeds a
// start/data/parity/stop serialiser whose txd output comes straight from a flop.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic        clk,
  input  logic        reset,
  axis_interface.Sink tx_stream,
  output logic        txd,
  output logic        busy
);

  localparam int           CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam uart_parity_t PARITY       = uart_parity_t'(2'(PARITY_MODE));
  localparam logic [2:0]   STOP_LAST    = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_tx_stream: CLKS_PER_BIT=%0d must be at least 4", CLKS_PER_BIT);
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_stream: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end
  if ((PARITY_MODE < 0) || (PARITY_MODE > 2)) begin : g_bad_parity
    $error("uart_tx_stream: PARITY_MODE=%0d must be 0, 1 or 2", PARITY_MODE);
  end

  uart_tx_state_t state_q, state_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic           hold_full_q, hold_full_d;
  logic [7:0]     hold_data_q, hold_data_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           tready;
  logic           handshake;
  logic           load;
  logic           tick;
  logic           parity_bit;

  // tready depends only on reset and registered state, never on tvalid.
  assign tready           = !reset && !hold_full_q;
  assign tx_stream.tready = tready;
  assign handshake        = tx_stream.tvalid && tready;
  assign parity_bit       = (PARITY == PARITY_ODD) ? ~^shift_q : ^shift_q;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (load),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    txd_d     = 1'b1;
    load      = 1'b0;
    unique case (state_q)
      ST_IDLE: load = hold_full_q;
      ST_START: begin
        txd_d = 1'b0;
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        txd_d = shift_q[bit_idx_q];
        if (tick) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        txd_d = parity_bit;
        if (tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_idx_q == STOP_LAST) begin
            state_d = ST_IDLE;
            load    = hold_full_q;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pending byte after the last stop bit goes straight into a new start bit.
    if (load) begin
      state_d   = ST_START;
      bit_idx_d = '0;
    end
  end

  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    shift_d     = shift_q;
    if (load) begin
      shift_d     = hold_data_q;
      hold_full_d = 1'b0;
    end
    if (handshake) begin
      hold_data_d = tx_stream.tdata;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
    end
  end

  // NOTE: the byte registers are deliberately not reset; hold_full_q and the
  // FSM state decide when their contents mean anything.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    shift_q     <= shift_d;
  end

  assign txd  = txd_q;
  assign busy = (state_q != ST_IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench: four transmitters (8N1, 8E1, 8O1, 8N2) at 16 clocks/bit,
// checked against a slot-level frame model and a mid-bit sampling receiver.
`timescale 1ns/1ps
module tb_uart_tx_stream;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 16;
  localparam int N_DUT  = 4;

  function automatic int pm_of(input int d);
    return (d == 1) ? 1 : ((d == 2) ? 2 : 0);
  endfunction

  function automatic int sb_of(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N_DUT-1:0] reset;
  logic [N_DUT-1:0] tvalid;
  logic [7:0]       tdata [N_DUT];
  wire  [N_DUT-1:0] tready;
  wire  [N_DUT-1:0] txd;
  wire  [N_DUT-1:0] busy;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    axis_interface #(.DATA_W(8)) u_if (.clk(clk));
    assign u_if.tdata  = tdata[g];
    assign u_if.tvalid = tvalid[g];
    assign tready[g]   = u_if.tready;

    uart_tx_stream #(
      .CLK_FREQ_HZ (CLK_HZ),
      .BAUD_RATE   (BAUD),
      .PARITY_MODE (pm_of(g)),
      .STOP_BITS   (sb_of(g))
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .tx_stream (u_if.Sink),
      .txd       (txd[g]),
      .busy      (busy[g])
    );
  end

  // History entry j holds the outputs as they stand after rising edge j.
  bit [N_DUT-1:0] txd_h[$];
  bit [N_DUT-1:0] busy_h[$];
  bit [N_DUT-1:0] trdy_h[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) begin
    #2;
    txd_h.push_back(txd);
    busy_h.push_back(busy);
    trdy_h.push_back(tready);
    cyc++;
  end

  function automatic logic txd_at(input int d, input int j);
    if (j < 0 || j >= txd_h.size()) return 1'bx;
    return txd_h[j][d];
  endfunction

  function automatic logic busy_at(input int d, input int j);
    if (j < 0 || j >= busy_h.size()) return 1'bx;
    return busy_h[j][d];
  endfunction

  function automatic logic trdy_at(input int d, input int j);
    if (j < 0 || j >= trdy_h.size()) return 1'bx;
    return trdy_h[j][d];
  endfunction

  // Reference frame model: slot 0 start, 1..8 data LSB first, optional parity, then stops.
  function automatic int frame_slots(input int d);
    int n = 9 + sb_of(d);
    if (pm_of(d) != 0) n++;
    return n;
  endfunction

  function automatic logic slot_level(input int d, input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (s == 9 && pm_of(d) != 0) return (pm_of(d) == 1) ? ^b : ~^b;
    return 1'b1;
  endfunction

  function automatic logic [7:0] decode_byte(input int d, input int f);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = txd_at(d, f + CPB * (i + 1) + CPB / 2);
    return b;
  endfunction

  function automatic int find_low(input int d, input int from, input int to);
    for (int j = from; j <= to; j++) if (txd_at(d, j) === 1'b0) return j;
    return -1;
  endfunction

  function automatic int find_busy_low(input int d, input int from, input int to);
    for (int j = from; j <= to; j++) if (busy_at(d, j) === 1'b0) return j;
    return -1;
  endfunction

  task automatic wait_until(input int idx);
    while (cyc <= idx) @(negedge clk);
  endtask

  // Presents bytes with tvalid held high; scramble replaces tdata every cycle.
  task automatic send_stream(input int d, input logic [7:0] q[$], input bit scramble,
                             output int e0, output logic [7:0] acc[$]);
    int idx = 0;
    int guard = 0;
    acc = {};
    e0 = -1;
    @(negedge clk);
    tvalid[d] = 1'b1;
    while (idx < q.size() && guard < 4000) begin
      tdata[d] = scramble ? 8'($urandom) : q[idx];
      if (tready[d] === 1'b1) begin
        if (idx == 0) e0 = cyc;
        acc.push_back(tdata[d]);
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    tvalid[d] = 1'b0;
    if (idx < q.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout dut%0d: accepted %0d bytes, required %0d", d, idx, q.size());
    end
  endtask

  // Checks a run of back-to-back frames starting two edges after handshake e0.
  task automatic check_frames(input string name, input int d, input int e0, input logic [7:0] q[$]);
    int len = frame_slots(d) * CPB;
    int search = e0;
    int fs;
    wait_until(e0 + 2 + (q.size() + 2) * len);
    for (int i = 0; i < q.size(); i++) begin
      int want_fs = e0 + 2 + i * len;
      int bad_t = -1;
      logic [7:0] got;
      fs = find_low(d, search, search + 4 * len);
      n_cmp++;
      if (fs != want_fs) begin
        n_bad++;
        $display("FAIL %s frame%0d_start: got %0d, want %0d", name, i, fs, want_fs);
        if (fs < 0) fs = want_fs;
      end
      for (int t = 0; t < len; t++)
        if (bad_t < 0 && txd_at(d, fs + t) !== slot_level(d, q[i], t / CPB)) bad_t = t;
      n_cmp++;
      if (bad_t >= 0) begin
        n_bad++;
        $display("FAIL %s frame%0d_wave: txd at offset %0d is %b, want %b", name, i, bad_t,
                 txd_at(d, fs + bad_t), slot_level(d, q[i], bad_t / CPB));
      end
      got = decode_byte(d, fs);
      n_cmp++;
      if (got !== q[i]) begin
        n_bad++;
        $display("FAIL %s frame%0d_byte: got %h, want %h", name, i, got, q[i]);
      end
      search = fs + len - CPB / 2;
    end
    fs = find_low(d, search, search + 2 * len);
    n_cmp++;
    if (fs != -1) begin
      n_bad++;
      $display("FAIL %s extra_frame: start at %0d, want none", name, fs);
    end
  endtask

  task automatic test_reset();
    int r;
    reset  = '1;
    tvalid = '0;
    for (int d = 0; d < N_DUT; d++) tdata[d] = 8'h00;
    tvalid[0] = 1'b1;
    tdata[0]  = 8'hC3;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (txd_h[cyc-1] !== 4'hF) begin n_bad++; $display("FAIL reset_txd: got %b, want 1111", txd_h[cyc-1]); end
    n_cmp++;
    if (busy_h[cyc-1] !== 4'h0) begin n_bad++; $display("FAIL reset_busy: got %b, want 0000", busy_h[cyc-1]); end
    n_cmp++;
    if (trdy_h[cyc-1] !== 4'h0) begin n_bad++; $display("FAIL reset_tready: got %b, want 0000", trdy_h[cyc-1]); end
    reset     = '0;
    tvalid[0] = 1'b0;
    r = cyc;
    wait_until(r + 4);
    n_cmp++;
    if (trdy_h[r] !== 4'hF) begin n_bad++; $display("FAIL release_tready: got %b, want 1111", trdy_h[r]); end
    n_cmp++;
    if (busy_h[r+3] !== 4'h0 || txd_h[r+3] !== 4'hF) begin
      n_bad++;
      $display("FAIL reset_ignores_tvalid: busy %b txd %b, want 0000 1111", busy_h[r+3], txd_h[r+3]);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] q[$];
    logic [7:0] acc[$];
    int e0, bl;
    q = {8'h55};
    send_stream(0, q, 1'b0, e0, acc);
    check_frames("single_55", 0, e0, q);
    n_cmp++;
    if (trdy_at(0, e0) !== 1'b0 || trdy_at(0, e0 + 1) !== 1'b1) begin
      n_bad++;
      $display("FAIL single_tready: got %b%b after E,E+1, want 01", trdy_at(0, e0), trdy_at(0, e0 + 1));
    end
    // The frame starts at edge E+1 and lasts ten bit times.
    bl = find_busy_low(0, e0, e0 + 20 * CPB);
    n_cmp++;
    if (bl != e0 + 1 + 10 * CPB) begin
      n_bad++;
      $display("FAIL single_busy_drop: got edge %0d, want %0d", bl, e0 + 1 + 10 * CPB);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] acc[$];
    int e0;
    int rises = 0;
    q = {8'hA5, 8'h3C, 8'hFF};
    send_stream(0, q, 1'b0, e0, acc);
    check_frames("b2b", 0, e0, q);
    for (int j = e0 + 1; j < e0 + 3 * 10 * CPB + 10; j++)
      if (trdy_at(0, j - 1) === 1'b0 && trdy_at(0, j) === 1'b1) rises++;
    n_cmp++;
    if (rises != 3) begin n_bad++; $display("FAIL b2b_tready_pulses: got %0d, want 3", rises); end
  endtask

  task automatic test_parity();
    logic [7:0] q[$];
    logic [7:0] acc[$];
    int e0, bl, len;
    for (int d = 1; d <= 2; d++) begin
      q = {8'h07, 8'($urandom), 8'($urandom)};
      len = frame_slots(d) * CPB;
      send_stream(d, q, 1'b0, e0, acc);
      check_frames((d == 1) ? "parity_even" : "parity_odd", d, e0, q);
      n_cmp++;
      if (txd_at(d, e0 + 2 + 9 * CPB + CPB / 2) !== ((d == 1) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL parity_bit_07 dut%0d: got %b, want %b", d,
                 txd_at(d, e0 + 2 + 9 * CPB + CPB / 2), (d == 1) ? 1'b1 : 1'b0);
      end
      bl = find_busy_low(d, e0, e0 + 5 * len);
      n_cmp++;
      if (bl != e0 + 1 + 3 * 176) begin
        n_bad++;
        $display("FAIL parity_busy_drop dut%0d: got edge %0d, want %0d", d, bl, e0 + 1 + 3 * 176);
      end
    end
  endtask

  task automatic test_two_stop();
    logic [7:0] q[$];
    logic [7:0] acc[$];
    int e0, run, s;
    q = {8'h00, 8'h00};
    send_stream(3, q, 1'b0, e0, acc);
    check_frames("two_stop", 3, e0, q);
    s = e0 + 2 + 176;
    run = 0;
    while (run < 200 && txd_at(3, s - 1 - run) === 1'b1) run++;
    n_cmp++;
    if (run != 32) begin n_bad++; $display("FAIL two_stop_high_run: got %0d cycles, want 32", run); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] q[$];
    logic [7:0] acc[$];
    int e0, rst_at, f;
    q = {8'h81, 8'h42};
    send_stream(0, q, 1'b0, e0, acc);
    rst_at = e0 + 2 + 4 * CPB + CPB / 2;
    while (cyc < rst_at) @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    wait_until(rst_at + 3 * 10 * CPB);
    n_cmp++;
    if (txd_at(0, rst_at - 1) !== 1'b0) begin n_bad++; $display("FAIL abort_bit3_before: got %b, want 0", txd_at(0, rst_at - 1)); end
    n_cmp++;
    if (txd_at(0, rst_at) !== 1'b1) begin n_bad++; $display("FAIL abort_txd: got %b, want 1", txd_at(0, rst_at)); end
    n_cmp++;
    if (busy_at(0, rst_at) !== 1'b0 || busy_at(0, rst_at + 1) !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: got %b%b, want 00", busy_at(0, rst_at), busy_at(0, rst_at + 1));
    end
    n_cmp++;
    if (trdy_at(0, rst_at) !== 1'b0 || trdy_at(0, rst_at + 1) !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_tready: got %b%b, want 01", trdy_at(0, rst_at), trdy_at(0, rst_at + 1));
    end
    f = find_low(0, rst_at, rst_at + 3 * 10 * CPB);
    n_cmp++;
    if (f != -1) begin n_bad++; $display("FAIL abort_no_frame: start at %0d, want none", f); end
  endtask

  task automatic test_scrambled_tdata();
    logic [7:0] q[$];
    logic [7:0] acc[$];
    int e0;
    q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(0, q, 1'b1, e0, acc);
    check_frames("scramble", 0, e0, acc);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_reset_mid_frame();
    test_scrambled_tdata();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
